// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-port memory responder: word type, access size
// encoding and FSM states.
package data_mem_responder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BE_W   = WORD_W / 8;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    DMR_IDLE,
    DMR_WAIT,
    DMR_RESP
  } dmr_state_e;

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Combinational lane steering: byte enables and replicated write word for
// stores, right-shift and mask for loads, and the size/alignment fault flag.
module data_mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]      size,
  input  logic [1:0]      addr_lo,
  input  word_t           wdata,
  output logic [BE_W-1:0] be,
  output word_t           wword,
  output logic            misalign,
  output logic [4:0]      rshift,
  output word_t           rmask
);

  always_comb begin
    be       = '0;
    wword    = '0;
    misalign = 1'b0;
    rmask    = '0;
    rshift   = {addr_lo, 3'b000};
    case (size)
      MEM_B: begin
        be    = BE_W'(4'b0001 << addr_lo);
        wword = {4{wdata[7:0]}};
        rmask = 32'h0000_00FF;
      end
      MEM_H: begin
        misalign = addr_lo[0];
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword    = {2{wdata[15:0]}};
        rmask    = 32'h0000_FFFF;
      end
      MEM_W: begin
        misalign = (addr_lo != 2'b00);
        be       = 4'b1111;
        wword    = wdata;
        rmask    = 32'hFFFF_FFFF;
      end
      default: misalign = 1'b1;
    endcase
    // A faulted access never enables any lane.
    if (misalign) be = '0;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data-port responder: req/gnt/rvalid handshake with
// configurable wait states in front of an internal word array.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter word_t       BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  dmr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp_en;

  logic             we_q;
  word_t            addr_q;
  logic [1:0]       size_q;
  word_t            wdata_q;

  logic             cur_we;
  word_t            cur_addr;
  logic [1:0]       cur_size;
  word_t            cur_wdata;

  logic [BE_W-1:0]  be;
  word_t            wword;
  word_t            rmask;
  logic [4:0]       rshift;
  logic             misalign;
  logic             in_range;
  logic             fault;
  logic [IDX_W-1:0] idx;
  word_t            rd_word;
  word_t            load_data;

  word_t            mem [DEPTH_WORDS];

  // Next state, grant and the strobe for the edge that enters RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_o   = 1'b0;
    resp_en = 1'b0;
    case (state_q)
      DMR_IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          if (WAIT_STATES > 0) begin
            state_d = DMR_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end else begin
            state_d = DMR_RESP;
            resp_en = 1'b1;
          end
        end
      end
      DMR_WAIT: begin
        if (cnt_q == '0) begin
          state_d = DMR_RESP;
          resp_en = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DMR_RESP: state_d = DMR_IDLE;
      default:  state_d = DMR_IDLE;
    endcase
  end

  // With zero wait states the response is formed from the live request.
  always_comb begin
    if (state_q == DMR_IDLE) begin
      cur_we    = we_i;
      cur_addr  = addr_i;
      cur_size  = size_i;
      cur_wdata = wdata_i;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_size  = size_q;
      cur_wdata = wdata_q;
    end
  end

  data_mem_lane_align u_lane_align (
    .size     (cur_size),
    .addr_lo  (cur_addr[1:0]),
    .wdata    (cur_wdata),
    .be       (be),
    .wword    (wword),
    .misalign (misalign),
    .rshift   (rshift),
    .rmask    (rmask)
  );

  // BASE_ADDR is window-aligned, so range is a compare of the upper bits.
  assign in_range  = (cur_addr[WORD_W-1:IDX_W+2] == BASE_ADDR[WORD_W-1:IDX_W+2]);
  assign fault     = misalign | ~in_range;
  assign idx       = cur_addr[IDX_W+1:2];
  assign rd_word   = mem[idx];
  assign load_data = (rd_word >> rshift) & rmask;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= DMR_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      wdata_q  <= '0;
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      rdata_o  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      if (state_q == DMR_IDLE && req_i) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        size_q  <= size_i;
        wdata_q <= wdata_i;
      end
      rvalid_o <= resp_en;
      err_o    <= resp_en & fault;
      rdata_o  <= (resp_en && !fault && !cur_we) ? load_data : '0;
    end
  end

  // Store commits on the edge entering RESP; storage itself is never reset.
  always_ff @(posedge clk_i) begin
    if (resp_en && cur_we && !fault) begin
      for (int k = 0; k < BE_W; k++) begin
        if (be[k]) mem[idx][8*k +: 8] <= wword[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboarded bench for data_mem_responder: one instance with one wait
// state, one with none for the back-to-back handshake.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          LAT   = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, gnt, rvalid, err;
  logic [31:0] addr, wdata, rdata;
  logic [1:0]  size;
  logic        req0, we0, gnt0, rvalid0, err0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [1:0]  size0;

  exp_t        exp_q[$];
  logic [7:0]  ref_mem [4*DEPTH];
  int          n_vec = 0;
  int          n_bad = 0;
  int          n_gnt = 0;
  int          n_rv  = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(1)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .size_i(size),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req0), .we_i(we0), .addr_i(addr0), .size_i(size0),
    .wdata_i(wdata0), .gnt_o(gnt0), .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0)
  );

  always @(posedge clk) begin
    if (rst_n && req && gnt) n_gnt++;
    if (rvalid) n_rv++;
  end

  // Byte-array reference: applies the access and returns the expected response.
  function automatic exp_t model(input bit w, input logic [31:0] a, input logic [1:0] s,
                                 input logic [31:0] d);
    exp_t r;
    int   n;
    int   off;
    bit   f;
    n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    f = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0) ||
        (a < BASE) || (a >= BASE + 4*DEPTH);
    r.rdata = '0;
    r.err   = f;
    if (!f) begin
      off = int'(a - BASE);
      for (int k = 0; k < n; k++) begin
        if (w) ref_mem[off+k] = d[8*k +: 8];
        else   r.rdata[8*k +: 8] = ref_mem[off+k];
      end
    end
    return r;
  endfunction

  // Present a request, hold it until granted; returns after the grant edge.
  task automatic issue(input bit w, input logic [31:0] a, input logic [1:0] s,
                       input logic [31:0] d, input bit push, output bit ok);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; size = s; wdata = d;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (gnt) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      if (push) exp_q.push_back(model(w, a, s, d));
      @(posedge clk);
      #1;
    end
    req = 1'b0;
  endtask

  // Count falling edges from the grant until rvalid shows, bounded.
  task automatic wait_rsp(output bit got, output int lat, output logic [31:0] rd,
                          output logic e);
    got = 1'b0; lat = 0; rd = 'x; e = 1'bx;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (rvalid) begin
        got = 1'b1; rd = rdata; e = err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; size = '0; wdata = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; size0 = '0; wdata0 = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (rvalid !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: rvalid=%b err=%b rdata=%h, want 0/0/0", rvalid, err, rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    req = 1'b1; addr = BASE; size = 2'd2;
    #1;
    n_vec++;
    if (gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_gnt_follow_hi: gnt=%b want 1", gnt);
    end
    req = 1'b0;
    #1;
    n_vec++;
    if (gnt !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_gnt_follow_lo: gnt=%b want 0", gnt);
    end
  endtask

  task automatic test_load_store();
    bit          tw [9] = '{1, 0, 1, 0, 0, 0, 1, 0, 0};
    logic [31:0] ta [9] = '{32'h1010, 32'h1010, 32'h1013, 32'h1010, 32'h1013, 32'h1012,
                            32'h1010, 32'h1010, 32'h1011};
    logic [1:0]  ts [9] = '{2, 2, 0, 2, 0, 1, 1, 2, 0};
    logic [31:0] td [9] = '{32'hDEAD_BEEF, 0, 32'hFFFF_FFA5, 0, 0, 0, 32'hAAAA_1234, 0, 0};
    logic [31:0] tr [9] = '{0, 32'hDEAD_BEEF, 0, 32'hA5AD_BEEF, 32'h0000_00A5, 32'h0000_A5AD,
                            0, 32'hA5AD_1234, 32'h0000_0012};
    bit ok, got; int lat; logic [31:0] rd; logic e; exp_t x;
    for (int i = 0; i < 9; i++) begin
      issue(tw[i], ta[i], ts[i], td[i], 1'b1, ok);
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL ls_gnt[%0d]: no grant within bound", i);
        continue;
      end
      wait_rsp(got, lat, rd, e);
      x = exp_q.pop_front();
      n_vec++;
      if (!got || lat != LAT) begin
        n_bad++;
        $display("FAIL ls_latency[%0d]: got=%b lat=%0d, want 1/%0d", i, got, lat, LAT);
      end
      n_vec++;
      if (rd !== x.rdata || e !== x.err) begin
        n_bad++;
        $display("FAIL ls_scoreboard[%0d]: rdata=%h err=%b, want %h/%b", i, rd, e, x.rdata, x.err);
      end
      n_vec++;
      if (rd !== tr[i] || e !== 1'b0) begin
        n_bad++;
        $display("FAIL ls_value[%0d]: rdata=%h err=%b, want %h/0", i, rd, e, tr[i]);
      end
    end
  endtask

  task automatic test_fault();
    bit          tw [9] = '{0, 1, 0, 1, 1, 0, 0, 1, 0};
    logic [31:0] ta [9] = '{32'h1011, 32'h1012, 32'h1010, 32'h1010, 32'h1013,
                            32'h1100, 32'h0FFC, 32'h1100, 32'h1010};
    logic [1:0]  ts [9] = '{1, 2, 3, 3, 1, 2, 2, 2, 2};
    logic [31:0] tr [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 32'hA5AD_1234};
    bit          te [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    bit ok, got; int lat; logic [31:0] rd; logic e; exp_t x;
    for (int i = 0; i < 9; i++) begin
      issue(tw[i], ta[i], ts[i], 32'hFFFF_FFFF, 1'b1, ok);
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL fault_gnt[%0d]: no grant within bound", i);
        continue;
      end
      wait_rsp(got, lat, rd, e);
      x = exp_q.pop_front();
      n_vec++;
      if (!got || lat != LAT) begin
        n_bad++;
        $display("FAIL fault_latency[%0d]: got=%b lat=%0d, want 1/%0d", i, got, lat, LAT);
      end
      n_vec++;
      if (rd !== x.rdata || e !== x.err) begin
        n_bad++;
        $display("FAIL fault_scoreboard[%0d]: rdata=%h err=%b, want %h/%b", i, rd, e, x.rdata, x.err);
      end
      n_vec++;
      if (rd !== tr[i] || e !== te[i]) begin
        n_bad++;
        $display("FAIL fault_value[%0d]: rdata=%h err=%b, want %h/%b", i, rd, e, tr[i], te[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok, got; int lat; logic [31:0] rd; logic e; exp_t x;
    issue(1'b1, 32'h1020, 2'd2, 32'hCAFE_F00D, 1'b1, ok);
    wait_rsp(got, lat, rd, e);
    x = exp_q.pop_front();
    n_vec++;
    if (!ok || !got || e !== x.err) begin
      n_bad++;
      $display("FAIL rstmid_prior_store: ok=%b got=%b err=%b", ok, got, e);
    end
    // Abort the store while it sits in WAIT; the model never sees it.
    issue(1'b1, 32'h1020, 2'd2, 32'h1234_5678, 1'b0, ok);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (rvalid !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: rvalid=%b err=%b rdata=%h, want 0/0/0", rvalid, err, rdata);
    end
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_rvalid_in_reset: rvalid=%b want 0", rvalid);
    end
    rst_n = 1'b1;
    got = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rvalid) got = 1'b1;
    end
    n_vec++;
    if (got) begin
      n_bad++;
      $display("FAIL rstmid_no_rvalid: rvalid=1 seen after abort, want none");
    end
    issue(1'b0, 32'h1020, 2'd2, 32'h0, 1'b1, ok);
    wait_rsp(got, lat, rd, e);
    x = exp_q.pop_front();
    n_vec++;
    if (!ok || !got || rd !== x.rdata || e !== x.err || rd !== 32'hCAFE_F00D) begin
      n_bad++;
      $display("FAIL rstmid_reload: rdata=%h err=%b, want %h/0 (prior value)", rd, e, 32'hCAFE_F00D);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = BASE; size0 = 2'd2; wdata0 = 32'h0000_0055;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_vec++;
      if (gnt0 !== (k % 2 == 0) || rvalid0 !== (k % 2 == 1)) begin
        n_bad++;
        $display("FAIL b2b_handshake[%0d]: gnt=%b rvalid=%b, want %b/%b",
                 k, gnt0, rvalid0, (k % 2 == 0), (k % 2 == 1));
      end
      if (k % 2 == 1) begin
        n_vec++;
        if (rdata0 !== ((k < 4) ? 32'h0 : 32'h55) || err0 !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_data[%0d]: rdata=%h err=%b, want %h/0",
                   k, rdata0, err0, (k < 4) ? 32'h0 : 32'h55);
        end
      end
      if (k == 3) we0 = 1'b0;
      @(negedge clk);
    end
    req0 = 1'b0;
  endtask

  task automatic test_random();
    bit ok, got; int lat; logic [31:0] rd; logic e; exp_t x;
    bit w; logic [31:0] a; logic [1:0] s;
    for (int i = 0; i < DEPTH + 160; i++) begin
      if (i < DEPTH) begin
        w = 1'b1; a = BASE + 32'(4*i); s = 2'd2;
      end else begin
        w = 1'($urandom_range(0, 1));
        s = 2'($urandom_range(0, 3));
        a = BASE - 32'd8 + 32'($urandom_range(0, 271));
        if ($urandom_range(0, 3) != 0) begin
          if (s == 2'd1) a[0] = 1'b0;
          if (s == 2'd2) a[1:0] = 2'b00;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      issue(w, a, s, $urandom, 1'b1, ok);
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL rand_gnt[%0d]: no grant within bound", i);
        continue;
      end
      wait_rsp(got, lat, rd, e);
      x = exp_q.pop_front();
      n_vec++;
      if (!got || lat != LAT || rd !== x.rdata || e !== x.err) begin
        n_bad++;
        $display("FAIL rand_rsp[%0d]: got=%b lat=%0d rdata=%h err=%b, want 1/%0d/%h/%b (a=%h s=%0d w=%b)",
                 i, got, lat, rd, e, LAT, x.rdata, x.err, a, s, w);
      end
      @(negedge clk);
      n_vec++;
      if (rvalid !== 1'b0) begin
        n_bad++;
        $display("FAIL rand_single_rvalid[%0d]: rvalid=%b want 0", i, rvalid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_fault();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (3) @(negedge clk);
    n_vec++;
    if (n_gnt != n_rv + 1) begin
      n_bad++;
      $display("FAIL grant_rvalid_count: grants=%0d rvalids=%0d, want grants = rvalids+1", n_gnt, n_rv);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
